// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock Gray-pointer FIFO (write and read controllers).
// Gray/binary conversions work on a fixed wide operand; callers zero-extend
// their pointer into it and size-cast the result back to the pointer width.
package fifo_pkg;

  localparam int GW = 32;

  // Pointer width for a given address width: one extra wrap bit.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Default geometry of the FIFO.
  localparam int ADDR_W_DEF = 4;
  localparam int PTR_W_DEF  = ptr_w(ADDR_W_DEF);

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/wr_ctrl_sync.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into the local clock.
module wr_ctrl_sync #(
  parameter int           W       = 5,
  parameter int           DLY     = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DLY-1:0][W-1:0] pipe;

  // Shift the asynchronous input through DLY flops; oldest stage is the output.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) pipe <= {DLY{RST_VAL}};
    else       pipe <= {pipe[DLY-2:0], d};
  end

  assign q = pipe[DLY-1];

endmodule

// File: rtl/wr_ctrl.sv
// Write-side controller of the dual-clock Gray-pointer FIFO (wr_clk domain).
// Optional feature macro: WR_CTRL_ALMOST_FULL_EN -- when defined, the
// almost_full comparator and register are built; otherwise almost_full is 0.
module wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int SYNC_DLY  = 2,
  parameter int AF_THRESH = 12
) (
  input  logic              wr_clk,
  input  logic              rst_,
  input  logic              wr_req_,
  input  logic [ADDR_W:0]   rd_ptr_g,
  input  logic              ovf_clr,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_ptr_b,
  output logic [ADDR_W:0]   wr_ptr_g,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int PW    = ptr_w(ADDR_W);
  localparam int DEPTH = 1 << ADDR_W;

  if (SYNC_DLY < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_param
    $error("wr_ctrl: SYNC_DLY must be >= 2 and AF_THRESH within 1..DEPTH");
  end

  logic [PW-1:0] rd_g_s;   // synchronized read pointer, Gray
  logic [PW-1:0] rd_b_s;   // synchronized read pointer, binary
  logic [PW-1:0] nxt;      // write pointer after this edge
  logic [PW-1:0] nxt_g;
  logic [PW-1:0] lvl;

  wr_ctrl_sync #(
    .W       (PW),
    .DLY     (SYNC_DLY),
    .RST_VAL ('0)
  ) wr_sync (
    .clk  (wr_clk),
    .rst_ (rst_),
    .d    (rd_ptr_g),
    .q    (rd_g_s)
  );

  // rst_ in the strobe keeps the memory quiet during an asynchronous reset.
  assign wr_en  = !wr_req_ && !full && rst_;
  assign nxt    = wr_ptr_b + {{(PW-1){1'b0}}, wr_en};
  assign nxt_g  = PW'(bin2gray(GW'(nxt)));
  assign rd_b_s = PW'(gray2bin(GW'(rd_g_s)));
  assign lvl    = nxt - rd_b_s;

  // Pointers, full, level and sticky overflow; Gray output comes from a flop.
  always_ff @(posedge wr_clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_b <= '0;
      wr_ptr_g <= '0;
      full     <= 1'b0;
      wr_level <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr_b <= nxt;
      wr_ptr_g <= nxt_g;
      full     <= (nxt[PW-1] != rd_b_s[PW-1]) &&
                  (nxt[PW-2:0] == rd_b_s[PW-2:0]);
      wr_level <= lvl;
      if (!wr_req_ && full) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

`ifdef WR_CTRL_ALMOST_FULL_EN
  // Almost-full registered from the same next-edge level as wr_level.
  always_ff @(posedge wr_clk or negedge rst_) begin
    if (!rst_) almost_full <= 1'b0;
    else       almost_full <= (lvl >= PW'(AF_THRESH));
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ctrl.sv
// Self-checking bench for wr_ctrl: a cycle model pushes expected outputs to a
// scoreboard queue when each cycle's stimulus is driven; they are popped and
// compared just after the following wr_clk rising edge.
module tb_wr_ctrl;

  localparam int AW  = 4;
  localparam int PW  = AW + 1;
  localparam int SD  = 2;
  localparam int AFT = 12;

  logic          wr_clk = 1'b0;
  logic          rst_   = 1'b0;
  logic          wr_req_ = 1'b1;
  logic          ovf_clr = 1'b0;
  logic [PW-1:0] rd_ptr_g = '0;
  logic          wr_en, full, almost_full, overflow;
  logic [PW-1:0] wr_ptr_b, wr_ptr_g, wr_level;

  int n_chk  = 0;
  int n_fail = 0;

  wr_ctrl #(.ADDR_W(AW), .SYNC_DLY(SD), .AF_THRESH(AFT)) dut (
    .wr_clk      (wr_clk),
    .rst_        (rst_),
    .wr_req_     (wr_req_),
    .rd_ptr_g    (rd_ptr_g),
    .ovf_clr     (ovf_clr),
    .wr_en       (wr_en),
    .wr_ptr_b    (wr_ptr_b),
    .wr_ptr_g    (wr_ptr_g),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic [PW-1:0] wp, gp, lvl;
    logic          full, af, ovf;
  } exp_t;
  exp_t sb[$];

  // cycle model state
  logic [PW-1:0] m_wp, m_lvl, m_s0, m_s1;
  logic          m_full, m_af, m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++)
      for (int j = i; j < PW; j++) b[i] = b[i] ^ g[j];
    return b;
  endfunction

  task automatic m_reset();
    m_wp = '0; m_lvl = '0; m_s0 = '0; m_s1 = '0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"},  wr_en,       0);
    chk({tag, "_wp"},     wr_ptr_b,    0);
    chk({tag, "_gp"},     wr_ptr_g,    0);
    chk({tag, "_full"},   full,        0);
    chk({tag, "_af"},     almost_full, 0);
    chk({tag, "_lvl"},    wr_level,    0);
    chk({tag, "_ovf"},    overflow,    0);
  endtask

  // One wr_clk cycle: drive at negedge, predict, compare after the posedge.
  task automatic step(input logic rq, input logic [PW-1:0] rg, input logic clr);
    exp_t e;
    logic en, nf;
    logic [PW-1:0] nx, rb;
    @(negedge wr_clk);
    wr_req_ = rq; rd_ptr_g = rg; ovf_clr = clr;
    #1;
    en = !rq && !m_full;
    chk("wr_en", wr_en, en);
    rb = g2b(m_s1);
    nx = m_wp + PW'(en);
    nf = (nx[PW-1] != rb[PW-1]) && (nx[PW-2:0] == rb[PW-2:0]);
    m_lvl = nx - rb;
`ifdef WR_CTRL_ALMOST_FULL_EN
    m_af = (m_lvl >= AFT);
`else
    m_af = 1'b0;
`endif
    if (!rq && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    m_full = nf;
    m_wp = nx;
    m_s1 = m_s0;
    m_s0 = rg;
    e.wp = nx; e.gp = b2g(nx); e.lvl = m_lvl;
    e.full = m_full; e.af = m_af; e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge wr_clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("wp",   wr_ptr_b,    e.wp);
      chk("gp",   wr_ptr_g,    e.gp);
      chk("lvl",  wr_level,    e.lvl);
      chk("full", full,        e.full);
      chk("af",   almost_full, e.af);
      chk("ovf",  overflow,    e.ovf);
    end
  endtask

  initial begin
    logic [PW-1:0] pwp, pgp;
    int wraps;

    // reset state, with a request pending to show wr_en is gated
    wr_req_ = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    chk_zero("rst");
    m_reset();
    @(negedge wr_clk);
    wr_req_ = 1'b1; rst_ = 1'b1;

    // short burst, then asynchronous reset mid-burst between edges
    repeat (5) step(1'b0, '0, 1'b0);
    chk("burst_wp", wr_ptr_b, 5);
    #2 rst_ = 1'b0;
    #1 chk_zero("async_rst");
    m_reset();
    @(negedge wr_clk);
    wr_req_ = 1'b1; rst_ = 1'b1;

    // wr_en follows wr_req_ after release
    step(1'b1, '0, 1'b0);

    // 17 requests against an idle reader: 16 accepted, then overflow
    for (int i = 0; i < 17; i++) begin
      step(1'b0, '0, 1'b0);
      if (i == 11) begin
        chk("af12_lvl", wr_level, 12);
`ifdef WR_CTRL_ALMOST_FULL_EN
        chk("af12_af", almost_full, 1);
`else
        chk("af12_af", almost_full, 0);
`endif
      end
      if (i == 10) chk("af11_af", almost_full, 0);
      if (i == 14) chk("full15", full, 0);
      if (i == 15) begin
        chk("full16_full", full, 1);
        chk("full16_wp", wr_ptr_b, 5'h10);
        chk("full16_gp", wr_ptr_g, 5'h18);
        chk("full16_lvl", wr_level, 16);
        chk("full16_ovf", overflow, 0);
      end
      if (i == 16) begin
        chk("ovf17_wp", wr_ptr_b, 5'h10);
        chk("ovf17_ovf", overflow, 1);
      end
    end

    // clear, then request+clear together while full: set wins
    step(1'b1, '0, 1'b1);
    chk("ovf_clr", overflow, 0);
    step(1'b0, '0, 1'b1);
    chk("ovf_set_wins", overflow, 1);

    // reader consumes one entry: full drops SYNC_DLY+1 edges later
    step(1'b0, 5'h01, 1'b0);
    chk("rd1_e1_full", full, 1);
    step(1'b0, 5'h01, 1'b0);
    chk("rd1_e2_full", full, 1);
    step(1'b0, 5'h01, 1'b0);
    chk("rd1_e3_full", full, 0);
    step(1'b0, 5'h01, 1'b0);
    chk("refill_full", full, 1);
    chk("refill_wp", wr_ptr_b, 5'h11);

    // bring the reader to distance 4 and let full clear
    repeat (3) step(1'b1, b2g(m_wp - 5'd4), 1'b1);
    chk("track_full", full, 0);

    // continuous writes with the reader tracking; crosses the pointer wrap
    wraps = 0;
    for (int i = 0; i < 24; i++) begin
      pwp = wr_ptr_b;
      pgp = wr_ptr_g;
      step(1'b0, b2g(m_wp - 5'd4), 1'b0);
      chk("gray_1bit", $countones(pgp ^ wr_ptr_g), 1);
      chk("track_nofull", full, 0);
      if (pwp == 5'h1F) begin
        wraps++;
        chk("wrap_prev_gp", pgp, 5'h10);
        chk("wrap_wp", wr_ptr_b, 5'h00);
        chk("wrap_gp", wr_ptr_g, 5'h00);
      end
    end
    chk("wrap_seen", wraps, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_ctrl.md
# wr_ctrl

Write-side controller of the dual-clock Gray-pointer FIFO, living entirely in the write clock domain. Accepts active-low write requests, drives the memory write enable and binary write address, and publishes a registered Gray write pointer for the read domain. Brings the read domain's Gray pointer across with a multi-flop synchronizer, decodes it, and derives full, fill level, almost-full and a sticky overflow flag.

## Interface
- ADDR_W, 4: memory address width; DEPTH = 2**ADDR_W entries.
- SYNC_DLY, 2: synchronizer stages on the incoming read pointer (≥2).
- AF_THRESH, 12: fill level at or above which almost_full asserts (1..DEPTH).
- wr_clk  in  1  write-domain clock, rising edge.
- rst_  in  1  asynchronous, active-low reset.
- wr_req_  in  1  write request, active low, sampled every wr_clk edge.
- rd_ptr_g  in  ADDR_W+1  read pointer, Gray-coded, from the read domain (asynchronous).
- ovf_clr  in  1  synchronous clear of overflow.
- wr_en  out  1  memory write strobe (combinational).
- wr_ptr_b  out  ADDR_W+1  binary write pointer; memory address = low ADDR_W bits.
- wr_ptr_g  out  ADDR_W+1  registered Gray write pointer to the read domain.
- full  out  1  FIFO full (registered).
- almost_full  out  1  level ≥ AF_THRESH (registered).
- wr_level  out  ADDR_W+1  fill level seen from the write side (registered, 0..DEPTH).
- overflow  out  1  sticky: a request arrived while full.

## Operation
- Pointers are ADDR_W+1 bits; MSB is the wrap bit. Binary arithmetic is modulo 2**(ADDR_W+1).
- wr_en = !wr_req_ && !full && rst_. A write is accepted on any edge where wr_en is 1.
- On an accepted write: wr_ptr_b <= wr_ptr_b+1; wr_ptr_g <= bin2gray(wr_ptr_b+1). Otherwise both hold.
- rd_ptr_g passes through SYNC_DLY flops (reset value 0) and is decoded to binary rd_b_s.
- With nxt = wr_ptr_b + wr_en, each edge: full <= (nxt[ADDR_W] != rd_b_s[ADDR_W]) && (nxt[ADDR_W-1:0] == rd_b_s[ADDR_W-1:0]); wr_level <= nxt - rd_b_s; almost_full <= (nxt - rd_b_s) ≥ AF_THRESH.
- overflow <= 1 on any edge with !wr_req_ && full; cleared by ovf_clr when not simultaneously set (set wins).
- Full is pessimistic: it stays set until the synchronized read pointer advances. The write side never over-writes unread data.
- Wrap-around: wr_ptr_b rolls from 2**(ADDR_W+1)-1 to 0; wr_ptr_g changes exactly one bit per increment, including across the wrap.
- Reset (async, any time, mid-burst included): all flops cleared immediately; wr_en forced 0 while rst_ low.

## Timing
- Reset values: wr_en 0, wr_ptr_b 0, wr_ptr_g 0, full 0, almost_full 0, wr_level 0, overflow 0, sync flops 0.
- Write latency: wr_en is in the same cycle as wr_req_ low; pointer and Gray output update on that edge.
- Full asserts on the edge of the write that fills the DEPTH-th slot; there is no extra accepted write.
- A rd_ptr_g change is reflected in full/wr_level/almost_full SYNC_DLY+1 wr_clk edges later.
- wr_ptr_g is driven straight from a flop, with no combinational path to the read domain.

## Configuration
- WR_CTRL_ALMOST_FULL_EN defined: almost_full logic and comparator compiled in as above.
- Not defined: almost_full tied to 0, AF_THRESH unused, and no comparator logic is generated. All other behaviour is identical.

## Structure
- Shared package fifo_pkg: the bin2gray and gray2bin functions, and a localparam computing pointer width from ADDR_W. The read controller uses the same package.
- One sub-module: the existing synchronizer, instantiated once as wr_sync (width ADDR_W+1, depth SYNC_DLY, reset value 0). All other logic is flat.

## Test plan
- Reset with rst_ low mid-burst and no clock toggling -> all outputs 0 immediately. Release rst_ -> wr_en follows wr_req_.
- ADDR_W=4, rd_ptr_g=0, wr_req_ low for 17 cycles -> 16 writes; full=1 on the 16th edge, with wr_ptr_b=0x10, wr_ptr_g=0x18, wr_level=16. 17th cycle: wr_en=0 and overflow=1. Then ovf_clr -> overflow 0.
- From full, set rd_ptr_g=0x01 -> full drops on the 3rd wr_clk edge (SYNC_DLY=2). One write is accepted, then full=1 again with wr_ptr_b=0x11.
- Continuous writes with rd_ptr_g tracking at distance 4 -> wr_ptr_b 0x1F→0x00 with wr_ptr_g 0x10→0x00. Exactly one Gray bit changes per write; full never asserts.
- AF_THRESH=12, macro defined -> almost_full rises on the 12th write edge with wr_level=12. Macro undefined -> almost_full stays 0.
- wr_req_ low while full and ovf_clr high on the same edge -> overflow=1 (set wins).
